// File: rtl/pcie_rst_seq_pkg.sv
// Shared state encoding and fault codes for the PCIe reset/bring-up sequencer.
package pcie_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_POR_HOLD   = 3'd0,
    ST_WAIT_CDO   = 3'd1,
    ST_PERST_HOLD = 3'd2,
    ST_WAIT_LINK  = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT      = 3'd5
  } seq_state_e;

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_CDO  = 2'd1;
  localparam logic [1:0] FLT_LINK = 2'd2;

endpackage

// File: rtl/pcie_rst_seq_ctrl_sync.sv
// Two-flop synchronizer for level inputs entering the sequencer clock domain.
module rst_seq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // First stage may go metastable; second stage re-times it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pcie_rst_seq_ctrl.sv
// Reset/bring-up sequencer for one CPM5N PCIe controller: POR -> CDO -> PERST -> link.
// Define PCIE_RST_SEQ_TIMEOUT_EN to enable CDO/link timeouts, link retries and FAULT.
module pcie_rst_seq_ctrl
  import pcie_rst_seq_pkg::*;
#(
  parameter int POR_CYCLES   = 500,
  parameter int PERST_CYCLES = 100,
  parameter int CDO_TIMEOUT  = 65535,
  parameter int LINK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cdo_done_ep,
  input  logic       cdo_done_rp,
  input  logic       link_up,
  input  logic       sw_rst_req,
  output logic       por_n,
  output logic       pcr_init_state,
  output logic       perst_n,
  output logic       user_reset,
  output logic       seq_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_CYCLES - 1);
`ifdef PCIE_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CDO_LAST   = CNT_W'(CDO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);
`endif

  generate
    if (POR_CYCLES < 1 || PERST_CYCLES < 1 || CDO_TIMEOUT < 1 || LINK_TIMEOUT < 1 ||
        MAX_RETRY < 0 || MAX_RETRY > 3 || CNT_W < 1 ||
        POR_CYCLES > (2 ** CNT_W) || PERST_CYCLES > (2 ** CNT_W) ||
        CDO_TIMEOUT > (2 ** CNT_W) || LINK_TIMEOUT > (2 ** CNT_W)) begin : g_bad_cfg
      $error("pcie_rst_seq_ctrl: parameter out of range");
    end
  endgenerate

  logic ep_done_s;
  logic rp_done_s;
  logic link_s;

  rst_seq_sync #(.W(1)) u_sync_ep (
    .clk (sys_clk), .rst_n (sys_rst_n), .d (cdo_done_ep), .q (ep_done_s)
  );
  rst_seq_sync #(.W(1)) u_sync_rp (
    .clk (sys_clk), .rst_n (sys_rst_n), .d (cdo_done_rp), .q (rp_done_s)
  );
  rst_seq_sync #(.W(1)) u_sync_link (
    .clk (sys_clk), .rst_n (sys_rst_n), .d (link_up), .q (link_s)
  );

  seq_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic             por_n_r, por_n_nxt_s;
  logic             pcr_r, pcr_nxt_s;
  logic             perst_n_r, perst_n_nxt_s;
  logic             user_rst_r, user_rst_nxt_s;
  logic             seq_done_r, seq_done_nxt_s;
  logic             fault_r, fault_nxt_s;
  logic [1:0]       fault_code_r, fault_code_nxt_s;
  logic [1:0]       retry_r, retry_nxt_s;
  logic             full_restart_s;
  logic             perst_restart_s;

  assign cnt_inc_s = (&cnt_r) ? cnt_r : (cnt_r + CNT_ONE);

  // Decide which restart, if any, sw_rst_req triggers; illegal states fall back to POR.
  always_comb begin
    full_restart_s  = 1'b0;
    perst_restart_s = 1'b0;
    case (state_r)
      ST_POR_HOLD, ST_WAIT_CDO: begin
        full_restart_s  = 1'b0;
        perst_restart_s = 1'b0;
      end
      ST_PERST_HOLD, ST_WAIT_LINK, ST_RUN: begin
        full_restart_s  = 1'b0;
        perst_restart_s = sw_rst_req;
      end
      ST_FAULT: begin
        full_restart_s  = sw_rst_req;
        perst_restart_s = 1'b0;
      end
      default: begin
        full_restart_s  = 1'b1;
        perst_restart_s = 1'b0;
      end
    endcase
  end

  // Next-state and next-output computation; restarts take priority over timeouts and link_up.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_inc_s;
    por_n_nxt_s      = por_n_r;
    pcr_nxt_s        = pcr_r;
    perst_n_nxt_s    = perst_n_r;
    user_rst_nxt_s   = user_rst_r;
    seq_done_nxt_s   = seq_done_r;
    fault_nxt_s      = fault_r;
    fault_code_nxt_s = fault_code_r;
    retry_nxt_s      = retry_r;
    if (full_restart_s) begin
      state_nxt_s      = ST_POR_HOLD;
      cnt_nxt_s        = CNT_ZERO;
      por_n_nxt_s      = 1'b0;
      pcr_nxt_s        = 1'b1;
      perst_n_nxt_s    = 1'b0;
      user_rst_nxt_s   = 1'b1;
      seq_done_nxt_s   = 1'b0;
      fault_nxt_s      = 1'b0;
      fault_code_nxt_s = FLT_NONE;
      retry_nxt_s      = 2'd0;
    end else if (perst_restart_s) begin
      state_nxt_s    = ST_PERST_HOLD;
      cnt_nxt_s      = CNT_ZERO;
      perst_n_nxt_s  = 1'b0;
      user_rst_nxt_s = 1'b1;
      seq_done_nxt_s = 1'b0;
      retry_nxt_s    = 2'd0;
    end else begin
      case (state_r)
        ST_POR_HOLD: begin
          if (cnt_r == POR_LAST) begin
            por_n_nxt_s = 1'b1;
            pcr_nxt_s   = 1'b0;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_WAIT_CDO;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_WAIT_CDO: begin
`ifdef PCIE_RST_SEQ_TIMEOUT_EN
          if (cnt_r == CDO_LAST) begin
            fault_nxt_s      = 1'b1;
            fault_code_nxt_s = FLT_CDO;
            cnt_nxt_s        = CNT_ZERO;
            state_nxt_s      = ST_FAULT;
          end else if (ep_done_s && rp_done_s) begin
`else
          if (ep_done_s && rp_done_s) begin
`endif
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_PERST_HOLD;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_PERST_HOLD: begin
          if (cnt_r == PERST_LAST) begin
            perst_n_nxt_s  = 1'b1;
            user_rst_nxt_s = 1'b0;
            cnt_nxt_s      = CNT_ZERO;
            state_nxt_s    = ST_WAIT_LINK;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_WAIT_LINK: begin
`ifdef PCIE_RST_SEQ_TIMEOUT_EN
          if (cnt_r == LINK_LAST) begin
            perst_n_nxt_s  = 1'b0;
            user_rst_nxt_s = 1'b1;
            cnt_nxt_s      = CNT_ZERO;
            if (retry_r < RETRY_MAX) begin
              retry_nxt_s = retry_r + 2'd1;
              state_nxt_s = ST_PERST_HOLD;
            end else begin
              fault_nxt_s      = 1'b1;
              fault_code_nxt_s = FLT_LINK;
              state_nxt_s      = ST_FAULT;
            end
          end else if (link_s) begin
`else
          if (link_s) begin
`endif
            seq_done_nxt_s = 1'b1;
            cnt_nxt_s      = CNT_ZERO;
            state_nxt_s    = ST_RUN;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_RUN: begin
          // Link loss re-waits for link without pulsing PERST again.
          if (!link_s) begin
            seq_done_nxt_s = 1'b0;
            cnt_nxt_s      = CNT_ZERO;
            state_nxt_s    = ST_WAIT_LINK;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_FAULT: begin
          perst_n_nxt_s  = 1'b0;
          user_rst_nxt_s = 1'b1;
          cnt_nxt_s      = cnt_r;
        end
        default: begin
          state_nxt_s = ST_POR_HOLD;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ST_POR_HOLD;
      cnt_r        <= CNT_ZERO;
      por_n_r      <= 1'b0;
      pcr_r        <= 1'b1;
      perst_n_r    <= 1'b0;
      user_rst_r   <= 1'b1;
      seq_done_r   <= 1'b0;
      fault_r      <= 1'b0;
      fault_code_r <= FLT_NONE;
      retry_r      <= 2'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      por_n_r      <= por_n_nxt_s;
      pcr_r        <= pcr_nxt_s;
      perst_n_r    <= perst_n_nxt_s;
      user_rst_r   <= user_rst_nxt_s;
      seq_done_r   <= seq_done_nxt_s;
      fault_r      <= fault_nxt_s;
      fault_code_r <= fault_code_nxt_s;
      retry_r      <= retry_nxt_s;
    end
  end

  assign por_n          = por_n_r;
  assign pcr_init_state = pcr_r;
  assign perst_n        = perst_n_r;
  assign user_reset     = user_rst_r;
  assign seq_done       = seq_done_r;
  assign fault          = fault_r;
  assign fault_code     = fault_code_r;
  assign state_o        = state_r;
  assign retry_cnt      = retry_r;

endmodule

// File: tb/tb_pcie_rst_seq_ctrl.sv
// Bench for pcie_rst_seq_ctrl: directed vector table, corner sequences and a randomized run
// checked cycle by cycle against a phase/timestamp reference model.
`timescale 1ns/1ps
module tb_pcie_rst_seq_ctrl;

  localparam int POR_C   = 8;
  localparam int PERST_C = 4;
  localparam int CDO_TO  = 1000;
  localparam int LINK_TO = 16;
  localparam int MAX_R   = 2;
`ifdef PCIE_RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int WAIT_L = 10;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int WAIT_L = 13;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cdo_done_ep = 1'b0, cdo_done_rp = 1'b0, link_up = 1'b0, sw_rst_req = 1'b0;
  logic       por_n, pcr_init_state, perst_n, user_reset, seq_done, fault;
  logic [1:0] fault_code, retry_cnt;
  logic [2:0] state_o;

  pcie_rst_seq_ctrl #(
    .POR_CYCLES(POR_C), .PERST_CYCLES(PERST_C), .CDO_TIMEOUT(CDO_TO),
    .LINK_TIMEOUT(LINK_TO), .MAX_RETRY(MAX_R), .CNT_W(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cdo_done_ep(cdo_done_ep),
    .cdo_done_rp(cdo_done_rp), .link_up(link_up), .sw_rst_req(sw_rst_req),
    .por_n(por_n), .pcr_init_state(pcr_init_state), .perst_n(perst_n),
    .user_reset(user_reset), .seq_done(seq_done), .fault(fault),
    .fault_code(fault_code), .state_o(state_o), .retry_cnt(retry_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number plus the edge at which the phase began; inputs seen
  // by the sequencer are the values sampled two edges earlier.
  int         m_phase, m_ent, m_cyc, m_retry, m_code;
  bit         m_fault;
  logic [2:0] h1, h2;

  function automatic logic [15:0] model_vec();
    logic pn, lk;
    pn = (m_phase != 0);
    lk = (m_phase == 3) || (m_phase == 4);
    return {3'b000, pn, ~pn, lk, ~lk, 1'(m_phase == 4), m_fault, 2'(m_code), 3'(m_phase), 2'(m_retry)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {3'b000, por_n, pcr_init_state, perst_n, user_reset, seq_done, fault, fault_code, state_o, retry_cnt};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ent = m_cyc; m_retry = 0; m_code = 0; m_fault = 1'b0;
    h1 = 3'b000; h2 = 3'b000;
  endtask

  task automatic goto_phase(input int p);
    m_phase = p;
    m_ent   = m_cyc + 1;
  endtask

  task automatic model_step();
    int   k;
    logic ep_s, rp_s, lk_s;
    k = m_cyc - m_ent;
    {ep_s, rp_s, lk_s} = h2;
    if (m_phase == 5 && sw_rst_req) begin
      goto_phase(0);
      m_fault = 1'b0; m_code = 0; m_retry = 0;
    end else if (sw_rst_req && m_phase >= 2 && m_phase <= 4) begin
      goto_phase(2);
      m_retry = 0;
    end else begin
      case (m_phase)
        0: if (k == POR_C - 1) goto_phase(1);
        1: if (TO_EN && k == CDO_TO - 1) begin m_fault = 1'b1; m_code = 1; goto_phase(5); end
           else if (ep_s && rp_s) goto_phase(2);
        2: if (k == PERST_C - 1) goto_phase(3);
        3: if (TO_EN && k == LINK_TO - 1) begin
             if (m_retry < MAX_R) begin m_retry++; goto_phase(2); end
             else begin m_fault = 1'b1; m_code = 2; goto_phase(5); end
           end else if (lk_s) goto_phase(4);
        4: if (!lk_s) goto_phase(3);
        default: ;
      endcase
    end
    h2 = h1;
    h1 = {cdo_done_ep, cdo_done_rp, link_up};
    m_cyc++;
  endtask

  task automatic clk_cycle();
    model_step();
    @(posedge sys_clk);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  localparam logic [15:0] RST_VEC = 16'b000_0_1_0_1_0_0_00_000_00;

  task automatic do_async_reset();
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_vec", dut_vec(), RST_VEC);
    @(posedge sys_clk);
    #1;
    check("held_reset_vec", dut_vec(), RST_VEC);
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic       ep, rp, lk;
    int         ncyc;
    logic [5:0] exp;   // {por_n, perst_n, seq_done, state}
  } vec_t;

  function automatic vec_t mk(input string nm, input logic ep, input logic rp, input logic lk,
                              input int n, input logic e_por, input logic e_perst,
                              input logic e_seq, input logic [2:0] e_st);
    vec_t v;
    v.name = nm; v.ep = ep; v.rp = rp; v.lk = lk; v.ncyc = n;
    v.exp = {e_por, e_perst, e_seq, e_st};
    return v;
  endfunction

  vec_t tbl[14];
  int   pulses, bad_len, low_len;
  logic prev_perst;

  initial begin
    tbl[0]  = mk("por_hold_c7",     1'b0, 1'b0, 1'b0, 7,      1'b0, 1'b0, 1'b0, 3'd0);
    tbl[1]  = mk("por_rise_c8",     1'b0, 1'b0, 1'b0, 1,      1'b1, 1'b0, 1'b0, 3'd1);
    tbl[2]  = mk("single_done_c20", 1'b1, 1'b0, 1'b0, 12,     1'b1, 1'b0, 1'b0, 3'd1);
    tbl[3]  = mk("sync_lat_c22",    1'b1, 1'b1, 1'b0, 2,      1'b1, 1'b0, 1'b0, 3'd1);
    tbl[4]  = mk("perst_hold_c23",  1'b1, 1'b1, 1'b0, 1,      1'b1, 1'b0, 1'b0, 3'd2);
    tbl[5]  = mk("perst_hold_c26",  1'b1, 1'b1, 1'b0, 3,      1'b1, 1'b0, 1'b0, 3'd2);
    tbl[6]  = mk("perst_rise_c27",  1'b1, 1'b1, 1'b0, 1,      1'b1, 1'b1, 1'b0, 3'd3);
    tbl[7]  = mk("wait_link",       1'b1, 1'b1, 1'b0, WAIT_L, 1'b1, 1'b1, 1'b0, 3'd3);
    tbl[8]  = mk("link_sync_lat",   1'b1, 1'b1, 1'b1, 2,      1'b1, 1'b1, 1'b0, 3'd3);
    tbl[9]  = mk("seq_done_rise",   1'b1, 1'b1, 1'b1, 1,      1'b1, 1'b1, 1'b1, 3'd4);
    tbl[10] = mk("link_drop",       1'b1, 1'b1, 1'b0, 3,      1'b1, 1'b1, 1'b0, 3'd3);
    tbl[11] = mk("link_drop_hold",  1'b1, 1'b1, 1'b0, 7,      1'b1, 1'b1, 1'b0, 3'd3);
    tbl[12] = mk("link_back_lat",   1'b1, 1'b1, 1'b1, 2,      1'b1, 1'b1, 1'b0, 3'd3);
    tbl[13] = mk("link_back_run",   1'b1, 1'b1, 1'b1, 1,      1'b1, 1'b1, 1'b1, 3'd4);

    m_cyc = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    model_reset();
    check("reset_vec", dut_vec(), RST_VEC);
    sys_rst_n = 1'b1;

    // Directed bring-up and link loss/restore.
    for (int i = 0; i < 14; i++) begin
      cdo_done_ep = tbl[i].ep; cdo_done_rp = tbl[i].rp; link_up = tbl[i].lk;
      run(tbl[i].ncyc);
      check(tbl[i].name, {10'd0, por_n, perst_n, seq_done, state_o}, {10'd0, tbl[i].exp});
    end

    // sw_rst_req in the same cycle the synchronized link_up reaches WAIT_LINK.
    link_up = 1'b0;
    run(3);
    check("drop_to_wait_link", {13'd0, state_o}, 16'd3);
    run(2);
    link_up = 1'b1;
    run(2);
    sw_rst_req = 1'b1;
    clk_cycle();
    sw_rst_req = 1'b0;
    check("sw_beats_link", {13'd0, state_o, perst_n, seq_done}, {13'd0, 3'd2, 1'b0, 1'b0});
    run(4);
    check("after_sw_hold", {13'd0, state_o, perst_n, seq_done}, {13'd0, 3'd3, 1'b1, 1'b0});
    run(1);
    check("relink_run", {13'd0, state_o, seq_done}, {13'd0, 3'd4, 1'b1});

    // Async reset in RUN, then replay from POR_HOLD with only one CDO done.
    cdo_done_ep = 1'b1; cdo_done_rp = 1'b0; link_up = 1'b0;
    do_async_reset();
    run(POR_C - 1);
    check("replay_por_low", {14'd0, por_n, pcr_init_state}, {14'd0, 1'b0, 1'b1});
    run(1);
    check("replay_por_rise", {13'd0, state_o, por_n}, {13'd0, 3'd1, 1'b1});
    run(100);
    sw_rst_req = 1'b1;
    clk_cycle();
    sw_rst_req = 1'b0;
    run(99);
    check("one_done_stays", {13'd0, state_o, perst_n}, {13'd0, 3'd1, 1'b0});

    // Link never comes up.
    cdo_done_rp = 1'b1;
    run(3);
    check("cdo_both_perst", {13'd0, state_o, perst_n}, {13'd0, 3'd2, 1'b0});
    run(4);
    check("cdo_both_link_wait", {13'd0, state_o, perst_n}, {13'd0, 3'd3, 1'b1});
`ifdef PCIE_RST_SEQ_TIMEOUT_EN
    pulses = 0; bad_len = 0; low_len = 0; prev_perst = perst_n;
    for (int i = 0; i < 56; i++) begin
      clk_cycle();
      if (!perst_n) low_len++;
      if (!prev_perst && perst_n) begin
        pulses++;
        if (low_len != PERST_C) bad_len++;
        low_len = 0;
      end
      prev_perst = perst_n;
      if (i == 54) check("no_fault_yet", {15'd0, fault}, 16'd0);
    end
    check("perst_repulses", 16'(pulses), 16'd2);
    check("repulse_len_errs", 16'(bad_len), 16'd0);
    check("link_fault", {8'd0, fault, fault_code, state_o, retry_cnt},
          {8'd0, 1'b1, 2'd2, 3'd5, 2'd2});
    check("fault_outputs", {13'd0, por_n, perst_n, user_reset}, {13'd0, 1'b1, 1'b0, 1'b1});
    sw_rst_req = 1'b1;
    clk_cycle();
    sw_rst_req = 1'b0;
    check("fault_sw_restart", dut_vec(), RST_VEC);
`else
    run(100);
    check("link_wait_forever", {11'd0, state_o, fault, retry_cnt}, {11'd0, 3'd3, 1'b0, 2'd0});
`endif

    // Randomized traffic against the reference model.
    cdo_done_ep = 1'b1; cdo_done_rp = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cdo_done_ep = ~cdo_done_ep;
      if ($urandom_range(0, 39) == 0) cdo_done_rp = ~cdo_done_rp;
      if ($urandom_range(0, 24) == 0) link_up = ~link_up;
      sw_rst_req = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 699) == 0) begin
        sw_rst_req = 1'b0;
        do_async_reset();
      end
      clk_cycle();
    end
    sw_rst_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
